// File: rtl/uart_frame_pkg.sv
// Shared state encoding, frame geometry and byte helpers for uart_frame_arb.
// Defining UART_FRAME_CKSUM_EN adds a sixth checksum byte to every frame.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int FRAME_DATA_BYTES = 4;

`ifdef UART_FRAME_CKSUM_EN
    localparam int CKSUM_BYTES = 1;
`else
    localparam int CKSUM_BYTES = 0;
`endif

    localparam int         FRAME_BYTES   = 1 + FRAME_DATA_BYTES + CKSUM_BYTES;
    localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_BYTES - 1);

    // Data bytes go out MSB first: k=0 is word[31:24].
    function automatic logic [7:0] data_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

`ifdef UART_FRAME_CKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [31:0] word);
        return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction
`endif

endpackage

// File: rtl/uart_frame_arb_rr_arbiter.sv
// Combinational rotate-priority encoder: first asserted request after index
// 'last', wrapping at N.
module rr_arbiter
    import uart_frame_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic         any,
    output logic [2:0]   winner
);

    int w_idx;

    // Walk from farthest to nearest so the nearest candidate after 'last' wins.
    always_comb begin
        any    = 1'b0;
        winner = 3'd0;
        w_idx  = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(last) + k) % N;
            if (req[w_idx]) begin
                any    = 1'b1;
                winner = 3'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_frame_arb.sv
// Round-robin arbiter and framer feeding one byte-wide UART transmitter.
// UART_FRAME_CKSUM_EN appends an XOR checksum of the four data bytes.
//
// state  | meaning
// S_IDLE | waiting for a request with the transmitter free
// S_SEND | ser_send held until the transmitter raises ser_busy
// S_WAIT | waiting for ser_busy to drop before the next byte or frame end
module uart_frame_arb
    import uart_frame_pkg::*;
#(
    parameter int         N        = 2,
    parameter logic [7:0] HDR_BASE = 8'h0A
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [7:0]      ser_data,
    output logic            ser_send,
    input  logic            ser_busy,
    output logic [2:0]      grant,
    output logic            active
);

    state_t       r_state,     w_state_nxt;
    logic [2:0]   r_byte_idx,  w_byte_idx_nxt;
    logic [2:0]   r_last,      w_last_nxt;
    logic [2:0]   r_grant,     w_grant_nxt;
    logic         r_active,    w_active_nxt;
    logic         r_send,      w_send_nxt;
    logic [7:0]   r_ser_data,  w_ser_data_nxt;
    logic [N-1:0] r_req_ready, w_req_ready_nxt;
    logic [31:0]  r_dlatch,    w_dlatch_nxt;

    logic         w_any;
    logic [2:0]   w_winner;
    logic [2:0]   w_byte_idx_inc;
    logic [7:0]   w_next_byte;

    rr_arbiter #(.N(N)) u_arb (
        .req    (req_valid),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    // Byte r_byte_idx+1 of the frame; data byte k sits at frame index k+1.
    always_comb begin
        w_byte_idx_inc = r_byte_idx + 3'd1;
        w_next_byte    = data_byte(r_dlatch, r_byte_idx[1:0]);
`ifdef UART_FRAME_CKSUM_EN
        if (w_byte_idx_inc == 3'(FRAME_DATA_BYTES + 1)) begin
            w_next_byte = xor_bytes(r_dlatch);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_byte_idx  <= 3'd0;
            r_last      <= 3'(N - 1);
            r_grant     <= 3'd0;
            r_active    <= 1'b0;
            r_send      <= 1'b0;
            r_ser_data  <= 8'h00;
            r_req_ready <= '0;
            r_dlatch    <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_active    <= w_active_nxt;
            r_send      <= w_send_nxt;
            r_ser_data  <= w_ser_data_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_dlatch    <= w_dlatch_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_byte_idx_nxt  = r_byte_idx;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_active_nxt    = r_active;
        w_send_nxt      = r_send;
        w_ser_data_nxt  = r_ser_data;
        w_req_ready_nxt = '0;
        w_dlatch_nxt    = r_dlatch;

        case (r_state)
            S_IDLE: begin
                // A busy transmitter here (e.g. mid-byte across reset) simply delays the grant.
                if (!ser_busy && w_any) begin
                    w_req_ready_nxt = N'(1) << w_winner;
                    w_dlatch_nxt    = req_data[32*w_winner +: 32];
                    w_grant_nxt     = w_winner;
                    w_last_nxt      = w_winner;
                    w_ser_data_nxt  = HDR_BASE + {5'd0, w_winner};
                    w_send_nxt      = 1'b1;
                    w_active_nxt    = 1'b1;
                    w_byte_idx_nxt  = 3'd0;
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (ser_busy) begin
                    w_send_nxt  = 1'b0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ser_busy) begin
                    if (r_byte_idx < LAST_BYTE_IDX) begin
                        w_ser_data_nxt = w_next_byte;
                        w_send_nxt     = 1'b1;
                        w_byte_idx_nxt = w_byte_idx_inc;
                        w_state_nxt    = S_SEND;
                    end else begin
                        w_active_nxt = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready = r_req_ready;
    assign ser_data  = r_ser_data;
    assign ser_send  = r_send;
    assign grant     = r_grant;
    assign active    = r_active;

endmodule

// File: tb/tb_uart_frame_arb.sv
// Scoreboard bench for uart_frame_arb: an N=2 instance (header base 0A) and
// an N=3 instance (header base FE) driven against a queue-level framing model.
module tb_uart_frame_arb;

    typedef struct packed {
        logic [7:0] b;
        logic [2:0] g;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [1:0]  req_valid_a;
    logic [63:0] req_data_a;
    logic [1:0]  req_ready_a;
    logic [7:0]  ser_data_a;
    logic        ser_send_a;
    logic        ser_busy_a;
    logic [2:0]  grant_a;
    logic        active_a;

    logic [2:0]  req_valid_b;
    logic [95:0] req_data_b;
    logic [2:0]  req_ready_b;
    logic [7:0]  ser_data_b;
    logic        ser_send_b;
    logic        ser_busy_b;
    logic [2:0]  grant_b;
    logic        active_b;

    logic busy_ma = 1'b0;
    logic busy_mb = 1'b0;
    logic force_busy = 1'b0;
    int   ucnt_a = 0;
    int   ucnt_b = 0;

    logic        pulse1 = 1'b0;
    logic [31:0] pulse_data1 = 32'h0;

    logic [31:0] srcq0[$];
    logic [31:0] srcq1[$];
    logic [31:0] srcqb[$];
    exp_t        expa[$];
    exp_t        expb[$];

    int model_last_a = 1;
    int rdy_a0 = 0, rdy_a1 = 0, rdy_b2 = 0;
    int bytes_seen_a = 0;
    int n_tests = 0, n_fail = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    assign ser_busy_a = busy_ma | force_busy;
    assign ser_busy_b = busy_mb;

    uart_frame_arb #(.N(2), .HDR_BASE(8'h0A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .ser_data(ser_data_a), .ser_send(ser_send_a),
        .ser_busy(ser_busy_a), .grant(grant_a), .active(active_a)
    );

    uart_frame_arb #(.N(3), .HDR_BASE(8'hFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .ser_data(ser_data_b), .ser_send(ser_send_b),
        .ser_busy(ser_busy_b), .grant(grant_b), .active(active_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // uart_tx stand-in: busy rises 2 cycles after a send is seen, holds 20 cycles.
    task automatic uart_step(input logic send, inout int cnt, output logic busy);
        if (!rst_n)          cnt = 0;
        else if (cnt == 0) begin
            if (send) cnt = 22;
        end else             cnt--;
        busy = (cnt >= 1 && cnt <= 20);
    endtask

    initial forever begin
        @(negedge clk);
        uart_step(ser_send_a, ucnt_a, busy_ma);
        uart_step(ser_send_b, ucnt_b, busy_mb);
    end

    // Sources: hold valid while words are queued, pop on the ready strobe.
    initial forever begin
        @(negedge clk);
        if (req_ready_a[0] && srcq0.size() > 0) void'(srcq0.pop_front());
        if (req_ready_a[1] && srcq1.size() > 0) void'(srcq1.pop_front());
        if (req_ready_b[2] && srcqb.size() > 0) void'(srcqb.pop_front());
        req_valid_a[0]     = (srcq0.size() > 0);
        req_data_a[31:0]   = (srcq0.size() > 0) ? srcq0[0] : 32'h0;
        req_valid_a[1]     = (srcq1.size() > 0) || pulse1;
        req_data_a[63:32]  = (srcq1.size() > 0) ? srcq1[0] : pulse_data1;
        req_valid_b        = {(srcqb.size() > 0), 2'b00};
        req_data_b         = {((srcqb.size() > 0) ? srcqb[0] : 32'h0), 64'h0};
    end

    // Monitor: every rising ser_send is one byte presented to the UART.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (ser_send_a && !prev_a) begin
                bytes_seen_a++;
                if (expa.size() == 0) chk("a_unexpected_byte", {24'h0, ser_data_a}, 32'hFFFF_FFFF);
                else begin
                    e = expa.pop_front();
                    chk("a_byte", {24'h0, ser_data_a}, {24'h0, e.b});
                    chk("a_grant", {29'h0, grant_a}, {29'h0, e.g});
                    chk("a_active", {31'h0, active_a}, 32'h1);
                end
            end
            if (ser_send_b && !prev_b) begin
                if (expb.size() == 0) chk("b_unexpected_byte", {24'h0, ser_data_b}, 32'hFFFF_FFFF);
                else begin
                    e = expb.pop_front();
                    chk("b_byte", {24'h0, ser_data_b}, {24'h0, e.b});
                    chk("b_grant", {29'h0, grant_b}, {29'h0, e.g});
                end
            end
            if (req_ready_a != 2'b00) begin
                chk("a_ready_onehot", $countones(req_ready_a), 1);
                if (req_ready_a[0]) rdy_a0++;
                if (req_ready_a[1]) rdy_a1++;
            end
            if (req_ready_b != 3'b000) begin
                chk("b_ready_src2_only", {29'h0, req_ready_b}, 32'h4);
                if (req_ready_b[2]) rdy_b2++;
            end
        end
        prev_a = ser_send_a;
        prev_b = ser_send_b;
    end

    task automatic push_frame(input bit to_b, input logic [7:0] hdr_base, input int s,
                              input logic [31:0] w);
        logic [7:0] b[6];
        int nb;
        exp_t e;
        b[0] = hdr_base + 8'(s);
        b[1] = w[31:24];
        b[2] = w[23:16];
        b[3] = w[15:8];
        b[4] = w[7:0];
        nb   = 5;
`ifdef UART_FRAME_CKSUM_EN
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
        nb   = 6;
`else
        b[5] = 8'h00;
`endif
        for (int i = 0; i < nb; i++) begin
            e.b = b[i];
            e.g = 3'(s);
            if (to_b) expb.push_back(e);
            else      expa.push_back(e);
        end
    endtask

    // Reference: with queued words held valid, each frame goes to the next
    // non-empty source after the previous winner, modulo 2.
    task automatic plan_a();
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic [31:0] w;
        int s;
        q0 = srcq0;
        q1 = srcq1;
        while (q0.size() + q1.size() > 0) begin
            s = (model_last_a + 1) % 2;
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) s = (s + 1) % 2;
            if (s == 0) w = q0.pop_front();
            else        w = q1.pop_front();
            push_frame(1'b0, 8'h0A, s, w);
            model_last_a = s;
        end
    endtask

    task automatic drain_a(input string nm);
        int t = 0;
        while ((expa.size() != 0 || active_a || srcq0.size() != 0 || srcq1.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drain_a"}, {31'h0, (t < 5000)}, 32'h1);
        chk({nm, "_leftover_a"}, expa.size(), 0);
    endtask

    task automatic drain_b(input string nm);
        int t = 0;
        while ((expb.size() != 0 || active_b || srcqb.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drain_b"}, {31'h0, (t < 5000)}, 32'h1);
    endtask

    initial begin
        int t, base0, base1, nw;
        logic [31:0] w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {30'h0, req_ready_a}, 0);
        chk("rst_send", {31'h0, ser_send_a}, 0);
        chk("rst_data", {24'h0, ser_data_a}, 0);
        chk("rst_grant", {29'h0, grant_a}, 0);
        chk("rst_active", {31'h0, active_a}, 0);
        chk("rst_b_active", {31'h0, active_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single word from source 0
        srcq0.push_back(32'h12345678);
        plan_a();
        t = 0;
        while (!req_ready_a[0] && t < 4) begin @(negedge clk); t++; end
        chk("t1_ready_latency", {31'h0, req_ready_a[0]}, 32'h1);
        drain_a("t1");
        chk("t1_ready0_count", rdy_a0, 1);
        chk("t1_ready1_count", rdy_a1, 0);
        chk("t1_active_low", {31'h0, active_a}, 0);

        // 2: both held valid, frames alternate
        base0 = rdy_a0; base1 = rdy_a1;
        srcq0.push_back(32'hAAAA0000); srcq0.push_back(32'hAAAA0000);
        srcq1.push_back(32'hBBBB0001); srcq1.push_back(32'hBBBB0001);
        plan_a();
        drain_a("t2");
        chk("t2_ready0_count", rdy_a0 - base0, 2);
        chk("t2_ready1_count", rdy_a1 - base1, 2);

        // 3: source 1 alone (checksum byte 04 when enabled)
        srcq1.push_back(32'h01020304);
        plan_a();
        drain_a("t3");

        // 5: source 1 pulses valid for one cycle during a source-0 frame
        srcq0.push_back(32'hC0FFEE11);
        plan_a();
        t = 0;
        while (!active_a && t < 20) begin @(negedge clk); t++; end
        chk("t5_frame_started", {31'h0, active_a}, 32'h1);
        repeat (5) @(negedge clk);
        base1 = rdy_a1;
        @(posedge clk); #2;
        pulse_data1 = 32'hDEADBEEF;
        pulse1 = 1'b1;
        @(posedge clk); #2;
        pulse1 = 1'b0;
        drain_a("t5");
        chk("t5_no_ready1", rdy_a1 - base1, 0);

        // 4: reset during data byte 2, busy held after release
        srcq0.push_back(32'h5A6B7C8D);
        plan_a();
        base0 = bytes_seen_a;
        t = 0;
        while (bytes_seen_a - base0 < 3 && t < 500) begin @(negedge clk); t++; end
        chk("t4_reached_byte2", {31'h0, (t < 500)}, 32'h1);
        base0 = rdy_a0;
        rst_n = 1'b0;
        force_busy = 1'b1;
        expa.delete();
        model_last_a = 1;
        repeat (2) @(negedge clk);
        chk("t4_rst_active", {31'h0, active_a}, 0);
        srcq0.push_back(32'h0F1E2D3C);
        rst_n = 1'b1;
        plan_a();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_no_send_busy", {31'h0, ser_send_a}, 0);
            chk("t4_no_ready_busy", {30'h0, req_ready_a}, 0);
        end
        force_busy = 1'b0;
        drain_a("t4");
        chk("t4_ready0_count", rdy_a0 - base0, 1);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) srcq0.push_back($urandom);
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) srcq1.push_back($urandom);
            plan_a();
            drain_a("rand");
        end

        // 6: N=3, only source 2, header wraps to 00
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 32'h89ABCDEF : $urandom;
            srcqb.push_back(w);
            push_frame(1'b1, 8'hFE, 2, w);
        end
        drain_b("t6");
        chk("t6_ready2_count", rdy_b2, 3);
        chk("t6_leftover_b", expb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
